fifo_stream_reader: RTL

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

---
 rtl/fifo_stream_reader.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: turns a FIFO with one-cycle read latency into a valid/ready stream via a 2-entry skid buffer.
// Define FIFO_READER_STATS_EN to add the 16-bit words_read pop counter output.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset_signal,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  fifo_empty_f,
  output logic                  fifo_read_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_output,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [15:0]           words_read
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            buf_count_q, buf_count_d;
  logic                  inflight_q, inflight_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  pop;
  logic                  capture;
  logic [2:0]            occupancy;
`ifdef FIFO_READER_STATS_EN
  logic [15:0]           words_read_q, words_read_d;
`endif

  // A read is only issued if its word is guaranteed a free slot when it lands next cycle.
  always_comb begin
    pop              = out_valid_q & out_ready;
    capture          = inflight_q & (state_q != FLUSH) & ~flush;
    occupancy        = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    fifo_read_enable = (state_q == RUN) & ~fifo_empty_f & ~flush & (occupancy < 3'd2);
  end

  always_comb begin
    if (flush) begin
      state_d = FLUSH;
    end else if (enable) begin
      state_d = RUN;
    end else begin
      state_d = IDLE;
    end
  end

  always_comb begin
    buf_count_d = buf_count_q;
    head_d      = head_q;
    tail_d      = tail_q;
    mem_d       = mem_q;
    inflight_d  = fifo_read_enable;
    if (flush) begin
      buf_count_d = 2'd0;
      head_d      = 1'b0;
      tail_d      = 1'b0;
    end else begin
      if (capture) begin
        mem_d[tail_q] = fifo_data_output;
        tail_d        = ~tail_q;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      buf_count_d = buf_count_q + {1'b0, capture} - {1'b0, pop};
    end
    // Outputs are registered from the next buffer state so they follow the buffer exactly.
    out_valid_d = (buf_count_d != 2'd0);
    out_data_d  = mem_d[head_d];
  end

`ifdef FIFO_READER_STATS_EN
  always_comb begin
    words_read_d = words_read_q + {15'd0, pop};
  end
`endif

  always_ff @(posedge clk or negedge reset_signal) begin
    if (!reset_signal) begin
      state_q      <= IDLE;
      buf_count_q  <= 2'd0;
      inflight_q   <= 1'b0;
      head_q       <= 1'b0;
      tail_q       <= 1'b0;
      mem_q[0]     <= '0;
      mem_q[1]     <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
`ifdef FIFO_READER_STATS_EN
      words_read_q <= 16'd0;
`endif
    end else begin
      state_q      <= state_d;
      buf_count_q  <= buf_count_d;
      inflight_q   <= inflight_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      mem_q[0]     <= mem_d[0];
      mem_q[1]     <= mem_d[1];
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
`ifdef FIFO_READER_STATS_EN
      words_read_q <= words_read_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef FIFO_READER_STATS_EN
  assign words_read = words_read_q;
`endif

endmodule
